demux_16ch_tdm: RTL and testbench



---
 rtl/demux_16ch_tdm_if.sv | 13 +
 rtl/demux_16ch_tdm.sv | 48 ++++
 tb/tb_demux_16ch_tdm.sv | 129 ++++++++++++
 3 files changed

// File: rtl/demux_16ch_tdm_if.sv
// demux_16ch_tdm_if: serial-in / parallel-out signal bundle for the TDM demultiplexer
interface demux_16ch_tdm_if;
  logic        en;
  logic        sync;
  logic        din;
  logic [15:0] dout;
  logic [3:0]  sel;
  logic        frame_valid;
  logic        sync_err;
  logic        locked;
  modport master (output en, sync, din, input dout, sel, frame_valid, sync_err, locked);
  modport slave  (input en, sync, din, output dout, sel, frame_valid, sync_err, locked);
endinterface

// File: rtl/demux_16ch_tdm.sv
// demux_16ch_tdm: recovers sync-marked 16-channel TDM frames into registered parallel words
module demux_16ch_tdm #(
  parameter bit RESYNC = 1'b1
) (
  input logic             clk,
  input logic             rst,
  demux_16ch_tdm_if.slave bus
);
  typedef enum logic {HUNT, RUN} state_t;
  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [15:0] shadow, shadow_n, dout, dout_n;
  logic        fv, fv_n, se, se_n;
  logic        run, start, miss, data;
  assign run   = state == RUN;
  assign start = bus.en && bus.sync && (!run || cnt == 4'd0 || RESYNC);
  assign miss  = bus.en && run && !bus.sync && cnt == 4'd0;
  assign data  = bus.en && run && !start && !miss;
  // state register
  always_ff @(posedge clk)
    state <= rst ? HUNT : state_n;
  // next state: lock on any accepted sync, drop lock when channel 0 arrives without one
  always_comb
    state_n = start ? RUN : miss ? HUNT : state;
  // datapath next values: steer the sample into its slot, publish on channel 15
  always_comb begin
    shadow_n = shadow;
    if (start) shadow_n[0] = bus.din;
    else if (data) shadow_n[cnt] = bus.din;
    cnt_n  = start ? 4'd1 : data ? cnt + 4'd1 : cnt;
    fv_n   = data && &cnt;
    dout_n = fv_n ? {bus.din, shadow[14:0]} : dout;
    se_n   = miss || (bus.en && run && bus.sync && cnt != 4'd0);
  end
  // datapath registers
  always_ff @(posedge clk) begin
    cnt    <= rst ? 4'd0 : cnt_n;
    shadow <= rst ? 16'd0 : shadow_n;
    dout   <= rst ? 16'd0 : dout_n;
    fv     <= rst ? 1'b0 : fv_n;
    se     <= rst ? 1'b0 : se_n;
  end
  assign bus.dout        = dout;
  assign bus.sel         = cnt;
  assign bus.frame_valid = fv;
  assign bus.sync_err    = se;
  assign bus.locked      = run;
endmodule

// File: tb/tb_demux_16ch_tdm.sv
// tb_demux_16ch_tdm: directed plus random stimulus against a frame-level queue model
module tb_demux_16ch_tdm;
  localparam bit RESYNC = 1'b1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit          mq[$];
  bit          m_lock = 1'b0;
  logic [15:0] m_dout = 16'd0;
  bit          m_fv = 1'b0;
  bit          m_se = 1'b0;
  demux_16ch_tdm_if bus();
  demux_16ch_tdm #(.RESYNC(RESYNC)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask
  task automatic model(input bit r, input bit e, input bit s, input bit d);
    m_fv = 1'b0;
    m_se = 1'b0;
    if (r) begin
      mq.delete();
      m_lock = 1'b0;
      m_dout = 16'd0;
    end else if (e) begin
      if (s && (!m_lock || mq.size() == 0 || RESYNC)) begin
        m_se = m_lock && mq.size() != 0;
        mq.delete();
        mq.push_back(d);
        m_lock = 1'b1;
      end else if (m_lock && mq.size() == 0) begin
        m_se = 1'b1;
        m_lock = 1'b0;
      end else if (m_lock) begin
        m_se = s;
        mq.push_back(d);
        if (mq.size() == 16) begin
          for (int i = 0; i < 16; i++) m_dout[i] = mq[i];
          m_fv = 1'b1;
          mq.delete();
        end
      end
    end
  endtask
  task automatic step(input bit r, input bit e, input bit s, input bit d);
    @(negedge clk);
    rst = r;
    bus.en = e;
    bus.sync = s;
    bus.din = d;
    @(posedge clk);
    model(r, e, s, d);
    cyc++;
    #1;
    chk("dout", bus.dout, m_dout);
    chk("sel", {12'd0, bus.sel}, 16'(mq.size()));
    chk("frame_valid", 16'(bus.frame_valid), 16'(m_fv));
    chk("sync_err", 16'(bus.sync_err), 16'(m_se));
    chk("locked", 16'(bus.locked), 16'(m_lock));
  endtask
  task automatic send_frame(input logic [15:0] w, input bit tog);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, i == 0, w[i]);
      if (tog && i != 15) step(1'b0, 1'b0, 1'($urandom), 1'($urandom));
    end
  endtask
  initial begin
    int c1, c2;
    logic [15:0] w3 [3];
    bus.en = 1'b0;
    bus.sync = 1'b0;
    bus.din = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("reset_dout", bus.dout, 16'd0);
    chk("reset_locked", 16'(bus.locked), 16'd0);
    send_frame(16'hA5C3, 1'b0);
    chk("a5c3", bus.dout, 16'hA5C3);
    chk("a5c3_fv", 16'(bus.frame_valid), 16'd1);
    w3 = '{16'h0001, 16'h8000, 16'hFFFF};
    c1 = cyc;
    for (int k = 0; k < 3; k++) begin
      send_frame(w3[k], 1'b0);
      c2 = cyc;
      chk("b2b_gap", 16'(c2 - c1), 16'd16);
      chk("b2b_dout", bus.dout, w3[k]);
      chk("b2b_fv", 16'(bus.frame_valid), 16'd1);
      c1 = c2;
    end
    send_frame(16'h1234, 1'b1);
    chk("toggle_dout", bus.dout, 16'h1234);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b1, 1'b0, 1'($urandom));
    chk("hunt_locked", 16'(bus.locked), 16'd0);
    send_frame(16'h00FF, 1'b0);
    chk("hunt_dout", bus.dout, 16'h00FF);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, i == 0, 1'($urandom));
    chk("pre_resync_sel", {12'd0, bus.sel}, 16'd7);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("resync_err", 16'(bus.sync_err), 16'd1);
    chk("resync_no_fv", 16'(bus.frame_valid), 16'd0);
    for (int i = 1; i < 16; i++) step(1'b0, 1'b1, 1'b0, 1'((16'hBEEF >> i) & 16'd1));
    chk("beef", bus.dout, 16'hBEEF);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("miss_err", 16'(bus.sync_err), 16'd1);
    chk("miss_locked", 16'(bus.locked), 16'd0);
    send_frame(16'h3C3C, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, i == 0, 1'($urandom));
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("rst_dout", bus.dout, 16'd0);
    chk("rst_sel", {12'd0, bus.sel}, 16'd0);
    chk("rst_locked", 16'(bus.locked), 16'd0);
    send_frame(16'h5A5A, 1'b0);
    chk("5a5a", bus.dout, 16'h5A5A);
    repeat (4000) begin
      bit s;
      s = mq.size() == 0 ? ($urandom % 8 != 0) : ($urandom % 40 == 0);
      step($urandom % 400 == 0, $urandom % 4 != 0, s, 1'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
